// File: rtl/axi_pkg.sv
// Shared AXI constants and the burst-generator FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_pkg;

  localparam logic [1:0]  BURST_INCR     = 2'b01;
  localparam int          BOUNDARY_BITS  = 12;
  localparam logic [12:0] BOUNDARY_BYTES = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // AxSIZE encoding: log2 of the number of bytes per beat
  function automatic logic [2:0] size_enc(input int beat_bytes);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == beat_bytes) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_ar_gen_if.sv
// Command-in / AR-out signal bundle for the read-address burst generator.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the command and AR sides.
interface axi_ar_gen_if #(
  parameter int AW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [23:0]   cmd_bytes;
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;

  // generator side: takes commands, drives the AR channel
  modport master (
    input  cmd_valid, cmd_addr, cmd_bytes, ar_ready,
    output cmd_ready, ar_valid, ar_addr, ar_len, ar_size, ar_burst
  );

  // environment side: issues commands, accepts AR requests
  modport slave (
    output cmd_valid, cmd_addr, cmd_bytes, ar_ready,
    input  cmd_ready, ar_valid, ar_addr, ar_len, ar_size, ar_burst
  );
endinterface

// File: rtl/axi_ar_len_calc.sv
// Beats for the next burst: min(remaining, MAX_BEATS, beats left before 4 KB page end).
// Latency: purely combinational.
// Backpressure: none.
module axi_ar_len_calc
  import axi_pkg::*;
#(
  parameter int DW        = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic [23:0] rem_beats,
  input  logic [11:0] addr_low,
  output logic [8:0]  beats
);

  localparam int BSH = $clog2(DW / 8);

  logic [12:0] bnd_bytes;
  logic [23:0] bnd_beats;
  logic [23:0] max_beats;
  logic [23:0] m_rem;
  logic [23:0] m_all;

  // addr_low is beat-aligned, so the page remainder divides exactly
  assign bnd_bytes = BOUNDARY_BYTES - {1'b0, addr_low};
  assign bnd_beats = 24'(bnd_bytes >> BSH);
  assign max_beats = 24'(MAX_BEATS);

  assign m_rem = (rem_beats < max_beats) ? rem_beats : max_beats;
  assign m_all = (m_rem < bnd_beats) ? m_rem : bnd_beats;

  // result never exceeds MAX_BEATS (<= 256), so 9 bits hold it
  assign beats = 9'(m_all);

endmodule

// File: rtl/axi_ar_gen.sv
// Splits a linear read command into AXI4 INCR bursts (<= MAX_BEATS, no 4 KB crossing).
// Latency: accept -> first ar_valid 2 cycles; one CALC bubble between bursts; done 1 cycle after last AR.
// Backpressure: ar_* held stable until ar_ready; cmd_ready low while a command is in progress.
// Optional AXI_AR_GEN_STAT_EN adds stat_bursts, a saturating count of AR handshakes.
module axi_ar_gen
  import axi_pkg::*;
#(
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  axi_ar_gen_if.master  bus,
  output logic          busy,
  output logic          done
`ifdef AXI_AR_GEN_STAT_EN
  ,
  output logic [15:0]   stat_bursts
`endif
);

  localparam int            BB         = DW / 8;
  localparam int            BSH        = $clog2(BB);
  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(BB - 1));

  state_t        state_q, state_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q;
  logic [23:0]   rem_q;
  logic [8:0]    beats_q;
  logic [AW-1:0] ar_addr_q;
  logic [7:0]    ar_len_q;

  logic          cmd_fire;
  logic          ar_fire;
  logic [23:0]   cmd_beats;
  logic [23:0]   rem_after;
  logic [8:0]    calc_beats;
  logic [AW-1:0] step_bytes;

  assign cmd_beats  = bus.cmd_bytes >> BSH;
  assign cmd_fire   = (state_q == ST_IDLE) && bus.cmd_valid;
  assign ar_fire    = (state_q == ST_ISSUE) && bus.ar_ready;
  assign rem_after  = rem_q - {15'd0, beats_q};
  assign step_bytes = AW'(beats_q) << BSH;

  axi_ar_len_calc #(
    .DW        (DW),
    .MAX_BEATS (MAX_BEATS)
  ) u_len_calc (
    .rem_beats (rem_q),
    .addr_low  (addr_q[BOUNDARY_BITS-1:0]),
    .beats     (calc_beats)
  );

  // next-state and done pulse decode
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_beats == 24'd0) done_d  = 1'b1;
          else                    state_d = ST_CALC;
        end
      end
      ST_CALC: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (bus.ar_ready) begin
          if (rem_after == 24'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register and registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // command cursor and registered AR fields; AR fields only change in CALC so they are stable in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q <= bus.cmd_addr & ALIGN_MASK;
        rem_q  <= cmd_beats;
      end
      if (state_q == ST_CALC) begin
        ar_addr_q <= addr_q;
        ar_len_q  <= 8'(calc_beats - 9'd1);
        beats_q   <= calc_beats;
      end
      if (ar_fire) begin
        addr_q <= addr_q + step_bytes;
        rem_q  <= rem_after;
      end
    end
  end

  // ar_valid decodes the state register only, so it never depends on ar_ready
  assign bus.ar_valid  = (state_q == ST_ISSUE);
  assign bus.ar_addr   = ar_addr_q;
  assign bus.ar_len    = ar_len_q;
  assign bus.ar_size   = size_enc(BB);
  assign bus.ar_burst  = BURST_INCR;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

`ifdef AXI_AR_GEN_STAT_EN
  logic [15:0] stat_q;

  // saturating AR handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stat_q <= '0;
    else if (ar_fire && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
  end

  assign stat_bursts = stat_q;
`endif

endmodule

// File: tb/tb_axi_ar_gen.sv
// Scoreboard bench for axi_ar_gen: stimulus pushes expected bursts, a negedge monitor checks.
// Reference model splits commands with plain arithmetic on byte addresses.
// AR backpressure is driven always-ready, random, or held low.
module tb_axi_ar_gen;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MB = 16;
  localparam int BB = DW / 8;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    bit          last;
  } ar_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done;
`ifdef AXI_AR_GEN_STAT_EN
  logic [15:0] stat_bursts;
`endif

  axi_ar_gen_if #(.AW(AW)) bus ();

  axi_ar_gen #(.DW(DW), .AW(AW), .MAX_BEATS(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef AXI_AR_GEN_STAT_EN
    ,
    .stat_bursts (stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  ar_exp_t exp_q[$];
  bit mon_en = 0;
  bit m_busy = 0;
  bit prev_vld = 0;
  bit hold_pend = 0;
  logic [31:0] held_addr;
  logic [7:0]  held_len;
  int exp_done_cyc = -10;
  int exp_vld_cyc = -10;
  int done_cnt = 0;
  int exp_done = 0;
  int hs_cnt = 0;
  int rdy_mode = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // reference model: chop the command into bursts by the page/length/remaining rules
  task automatic push_model(input logic [31:0] a_in, input logic [23:0] bytes);
    logic [31:0] a;
    longint rem, page_left, b;
    ar_exp_t e;
    a = a_in - (a_in % BB);
    rem = longint'(bytes) / BB;
    while (rem > 0) begin
      page_left = (4096 - (longint'(a) % 4096)) / BB;
      b = rem;
      if (b > MB) b = MB;
      if (b > page_left) b = page_left;
      e.addr = a;
      e.len  = 8'(b - 1);
      e.last = (rem == b);
      exp_q.push_back(e);
      a = a + 32'(b * BB);
      rem = rem - b;
    end
  endtask

  // monitor: decoupled from stimulus, compares whatever the DUT presents
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("cmd_ready", bus.cmd_ready, !m_busy);
      check_eq("busy", busy, m_busy);
      check_eq("ar_valid_idle", bus.ar_valid & !m_busy, 0);
      if (done || cyc == exp_done_cyc) check_eq("done_timing", done, cyc == exp_done_cyc);
      if (done) done_cnt++;
      if (bus.ar_valid && !prev_vld) check_eq("ar_valid_latency", cyc, exp_vld_cyc);
      if (hold_pend) check_eq("ar_stable", {bus.ar_valid, bus.ar_addr, bus.ar_len}, {1'b1, held_addr, held_len});
      if (bus.ar_valid) begin
        check_eq("ar_size", bus.ar_size, 3'd3);
        check_eq("ar_burst", bus.ar_burst, 2'b01);
      end
      if (bus.ar_valid && bus.ar_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ar_unexpected: got addr 0x%0h len %0d, expected none", bus.ar_addr, bus.ar_len);
        end else begin
          ar_exp_t e;
          e = exp_q.pop_front();
          check_eq("ar_addr", bus.ar_addr, e.addr);
          check_eq("ar_len", bus.ar_len, e.len);
          hs_cnt++;
          if (e.last) begin
            m_busy = 0;
            exp_done_cyc = cyc + 1;
          end else begin
            exp_vld_cyc = cyc + 2;
          end
        end
      end
      hold_pend = bus.ar_valid && !bus.ar_ready;
      held_addr = bus.ar_addr;
      held_len  = bus.ar_len;
      prev_vld  = bus.ar_valid;
      if (bus.cmd_valid && bus.cmd_ready) begin
        if ((bus.cmd_bytes / BB) == 0) exp_done_cyc = cyc + 1;
        else begin
          m_busy = 1;
          exp_vld_cyc = cyc + 2;
        end
      end
    end
  end

  // AR backpressure driver
  initial begin
    bus.ar_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.ar_ready = 1'b1;
        1:       bus.ar_ready = ($urandom_range(0, 99) < 60);
        default: bus.ar_ready = 1'b0;
      endcase
    end
  end

  // present a command and return just after the edge that accepts it
  task automatic send(input logic [31:0] a, input logic [23:0] b);
    int t;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_bytes = b;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) fail_now("cmd_accept");
    push_model(a, b);
    exp_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (done_cnt != exp_done && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("done_count", done_cnt, exp_done);
  endtask

  initial begin
    logic [31:0] a;
    logic [23:0] b;
    int t;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_bytes = '0;
    #12;
    check_eq("rst_ar_valid", bus.ar_valid, 0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ar_addr", bus.ar_addr, 0);
    check_eq("rst_ar_len", bus.ar_len, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ar_size", bus.ar_size, 3'd3);
    check_eq("rst_ar_burst", bus.ar_burst, 2'b01);
`ifdef AXI_AR_GEN_STAT_EN
    check_eq("rst_stat", stat_bursts, 0);
`endif
    mon_en = 1;
    @(posedge clk);
    #1;

    // directed: page-aligned split, 4 KB split, zero length
    rdy_mode = 0;
    send(32'h0000_1000, 24'd256);
    bus.cmd_valid = 1'b0;
    wait_idle();
    send(32'h0000_0FF0, 24'd64);
    bus.cmd_valid = 1'b0;
    wait_idle();
    send(32'h0000_5000, 24'd0);
    bus.cmd_valid = 1'b0;
    wait_idle();

    // ar_ready held low for several cycles
    rdy_mode = 2;
    send(32'h0000_2000, 24'd8);
    bus.cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    rdy_mode = 0;
    wait_idle();

    // cmd_valid held high across a busy period: second command waits for IDLE
    rdy_mode = 1;
    send(32'h0000_7F80, 24'd200);
    send(32'h0001_0008, 24'd136);
    bus.cmd_valid = 1'b0;
    wait_idle();

    // randomized commands, including page-end and address-wrap cases
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        1: a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
        2: a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) b = 24'd0;
      else if ($urandom_range(0, 3) == 0) b = 24'($urandom_range(0, 600) * BB);
      else b = 24'($urandom_range(1, 64) * BB);
      send(a, b);
      if ($urandom_range(0, 1) == 0) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    check_eq("scoreboard_empty", exp_q.size(), 0);
`ifdef AXI_AR_GEN_STAT_EN
    check_eq("stat_bursts", stat_bursts, hs_cnt);
`endif

    // reset asserted while an AR is pending
    rdy_mode = 2;
    send(32'h0000_3000, 24'd128);
    bus.cmd_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.ar_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ar_valid) fail_now("ar_valid_before_reset");
    mon_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ar_valid", bus.ar_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_busy = 0;
    hold_pend = 0;
    prev_vld = 0;
    done_cnt = 0;
    exp_done = 0;
    hs_cnt = 0;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("post_rst_done", done, 0);
`ifdef AXI_AR_GEN_STAT_EN
    check_eq("post_rst_stat", stat_bursts, 0);
`endif
    mon_en = 1;

    // normal operation resumes after reset
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send(32'h0000_4FC0, 24'd512);
    bus.cmd_valid = 1'b0;
    wait_idle();
    check_eq("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_ar_gen.md
# axi_ar_gen

Read-address burst generator for the AXI master datapath. Accepts a single linear read command (start address and byte count), splits it into AXI4 INCR bursts, and issues them on an AR valid/ready channel. Bursts are limited to a programmable maximum length and never cross a 4 KB boundary. The AR output drives the AR-channel register slice directly, so it must obey valid/ready stability rules.

## Interface
- DW, 64: AXI data width in bits; power of two, 8..1024; beat bytes BB = DW/8
- AW, 32: address width
- MAX_BEATS, 16: maximum beats per burst; 1..256
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command
- cmd_addr  input  AW  start byte address; low log2(BB) bits ignored (treated as 0)
- cmd_bytes  input  24  byte count; multiple of BB; 0 allowed
- ar_valid  output  1  AR request
- ar_ready  input  1  AR accept
- ar_addr  output  AW  burst start address
- ar_len  output  8  beats minus one
- ar_size  output  3  constant log2(BB)
- ar_burst  output  2  constant INCR (2'b01)
- busy  output  1  command in progress
- done  output  1  one-cycle pulse after the last AR handshake of a command

Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- FSM states: IDLE, CALC, ISSUE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr (aligned) and rem_beats = cmd_bytes/BB. If rem_beats==0, go IDLE and pulse done next cycle; otherwise go CALC.
- CALC: beats = min(rem_beats, MAX_BEATS, (4096 - addr[11:0])/BB). Register ar_addr=addr, ar_len=beats-1. Go ISSUE.
- ISSUE: ar_valid=1, all ar_* held stable until ar_ready. On handshake: addr += beats*BB, rem_beats -= beats. Go IDLE with done=1 if rem_beats becomes 0, else go CALC.
- cmd_ready=0 outside IDLE; busy = (state != IDLE).
- Address increment wraps modulo 2^AW; no error is flagged.
- Reset values: ar_valid 0, ar_addr 0, ar_len 0, busy 0, done 0, cmd_ready 1; ar_size/ar_burst constant.

## Timing
- Command accepted at cycle N -> first ar_valid at N+2.
- AR handshake at cycle M -> next ar_valid at M+2 (CALC bubble); done at M+1 for the final burst.
- Zero-length command at N -> done at N+1, no AR.
- ar_valid never deasserts without handshake; ar_valid does not depend combinationally on ar_ready.
- Reset asserted mid-ISSUE: ar_valid drops asynchronously; the command is discarded.

## Configuration
- AXI_AR_GEN_STAT_EN defined: adds output stat_bursts [15:0], counting AR handshakes since reset, saturating at 0xFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package axi_pkg: BURST_INCR constant, 4 KB boundary constant (12 bits), size-encoding function log2 of beat bytes, FSM state encoding.
- One natural sub-module: axi_ar_len_calc, purely combinational min-of-three beat computation (rem_beats, MAX_BEATS, boundary beats).

## Test plan
All scenarios use DW=64, MAX_BEATS=16.
- addr 0x1000, bytes 256 -> AR 0x1000 len 15, AR 0x1080 len 15, done once.
- addr 0x0FF0, bytes 64 -> AR 0x0FF0 len 1, AR 0x1000 len 5 (4 KB split).
- addr 0x2000, bytes 8, ar_ready low for 5 cycles -> ar_addr/ar_len stable, single AR len 0, done at handshake+1.
- bytes 0 -> no ar_valid, done at N+1, cmd_ready back at N+1.
- cmd_valid held high while busy -> cmd_ready 0 until IDLE; second command starts only after done.
- rst_n pulsed low during ISSUE -> ar_valid 0 immediately, cmd_ready 1 after release, stat_bursts 0 when AXI_AR_GEN_STAT_EN is defined.
